one_hot_rr_arbiter: RTL
=======================

# one_hot_rr_arbiter

Parametrised N-input round-robin arbiter with packet locking, a one-hot grant and a registered output stage. It sits at each NoC router output port and replaces a bare one-hot mux plus external arbiter. It selects one of `N_REQ` valid/ready input channels, holds the grant for the whole packet (head to tail flit), and forwards the selected flit into a single output register. The output register carries the binary source index.

## Interface
- `N_REQ`, 4: number of requesting input channels (≥1).
- `DATA_WIDTH`, 32: flit payload width.
- `BIN_WIDTH`, ceil(log2(`N_REQ`)), minimum 1: width of the source index.
- `HOLD_ENABLE`, 1:
  - 1: the grant locks from a non-tail flit until the tail flit.
  - 0: every flit is arbitrated independently.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  `N_REQ`  per-channel flit valid.
- `in_tail`  in  `N_REQ`  per-channel tail marker for the presented flit.
- `in_data`  in  `N_REQ*DATA_WIDTH`  flits; channel i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- `in_ready`  out  `N_REQ`  per-channel accept; at most one bit set.
- `grant_onehot`  out  `N_REQ`  combinational current winner (one-hot or zero).
- `locked`  out  1  registered; 1 while a packet is in progress.
- `out_valid`  out  1  output register holds a flit.
- `out_data`  out  `DATA_WIDTH`  registered flit.
- `out_tail`  out  1  registered tail marker.
- `out_src_bin`  out  `BIN_WIDTH`  binary index of the channel that supplied `out_data`.
- `out_ready`  in  1  downstream accept.

## Operation
State registers:
- `ptr`: one-hot, marks the last-served channel.
- `lock_q` and `lock_idx`.
- The output register: `out_valid`, `out_data`, `out_tail`, `out_src_bin`.

Control signals:
- `can_load = !out_valid | out_ready`.
- Input transfer on channel i: `in_valid[i] & in_ready[i]`.
- `in_ready = grant_onehot & {N_REQ{can_load}}`. `in_ready` is forced to 0 while `reset` is high.

Grant selection (combinational):
- **Locked** (`lock_q`=1): `grant_onehot` = bit `lock_idx` if `in_valid[lock_idx]` is set, else 0. Other channels are never granted while locked, even if valid.
- **Unlocked**: the first valid channel searching upward from `ptr`+1 modulo `N_REQ` wins. Channel `ptr` itself is searched last. No valid channel gives `grant_onehot` = 0.

On each transfer:
- The output register loads the winner's data and tail.
- `out_src_bin` loads the winner's index, produced by a one-hot-to-binary conversion of the grant.
- `out_valid` is set to 1.

Output register:
- If `out_valid` is set, `out_ready` is set and no transfer occurs: `out_valid` clears.
- `out_data`, `out_tail` and `out_src_bin` hold their value when not loaded.

Lock and pointer update (`HOLD_ENABLE`=1):
- Transfer with tail=0: `lock_q`←1, `lock_idx`←winner.
- Transfer with tail=1: `lock_q`←0, `ptr`←winner.
- A single-flit packet (tail=1 on the head flit) never sets the lock.

With `HOLD_ENABLE`=0:
- `lock_q` stays 0.
- `ptr`←winner on every transfer.
- `in_tail` is only forwarded to `out_tail`.

`locked` = `lock_q`.

Special case `N_REQ`=1:
- `out_src_bin` is constant 0.
- The rotation degenerates to a pass-through register.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_tail`=0, `out_src_bin`=0, `locked`=0, `ptr`=bit `N_REQ`-1. After reset, channel 0 has the highest priority.
- Latency: 1 cycle. A flit transferred at edge k is visible on `out_*` after edge k.
- Throughput: 1 flit per cycle while `out_ready` stays 1.
- Backpressure: `out_valid`=1 with `out_ready`=0 keeps `in_ready` at all zeros and holds the output register stable.
- Locked channel drops `in_valid` mid-packet: bubble; no grant to anyone; lock held.
- Simultaneous unload and load in one cycle is allowed and gives no bubble.
- `reset` asserted mid-packet: the lock, `ptr` and the output register clear immediately (asynchronously), and any flit in the output register is discarded. The first grant after release goes to the lowest-index valid channel.
- `grant_onehot` may be non-zero while `can_load`=0; no transfer and no state change occur in that case.

## Test plan
- **Reset**: hold `reset`=1 with all inputs valid -> all outputs at reset values and `in_ready`=0. On release with `in_valid`=4'b1111, tail=1 -> `in_ready`=4'b0001. `out_src_bin` sequence 0,1,2,3,0 on consecutive cycles with `out_ready`=1.
- **Packet lock**: ch2 sends 3 flits (tail on the 3rd) while ch0 and ch1 are valid (N_REQ=4, HOLD_ENABLE=1) -> `out_src_bin`=2,2,2 then 0. `locked`=1 for exactly 2 cycles.
- **Lock bubble**: ch1 sends a head flit (tail=0), then drops `in_valid` for 2 cycles while ch3 is valid -> no transfers, `out_valid` goes 0 after the drain, `locked` stays 1. ch1 tail then resumes -> the next grant goes to ch3.
- **Backpressure**: `out_ready`=0 for 4 cycles with `out_data`=0xA5A5A5A5 held -> `in_ready`=0 and `out_data` unchanged. On `out_ready`=1 the new flit loads in the same cycle.
- **Reset mid-packet**: pulse `reset` asynchronously between clock edges during ch3's packet -> `locked`=0 and `out_valid`=0 before the next edge. The next grant goes to the lowest valid index.
- **HOLD_ENABLE=0**: ch0 and ch1 both stream tail=0 flits -> `out_src_bin` alternates 0,1,0,1 and `locked` stays 0.

Source files
------------

// File: rtl/one_hot_rr_arbiter.sv
// one_hot_rr_arbiter
// Round-robin arbiter for one NoC router output port. It picks one of N_REQ
// valid/ready input channels and, when HOLD_ENABLE is set, keeps the grant on
// that channel from the head flit through the tail flit. The winning flit is
// captured in a single output register together with its binary source index.

module one_hot_rr_arbiter #(
   parameter int N_REQ       = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int BIN_WIDTH   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   parameter bit HOLD_ENABLE = 1'b1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_REQ-1:0]              in_valid,
   input  logic [N_REQ-1:0]              in_tail,
   input  logic [N_REQ*DATA_WIDTH-1:0]   in_data,
   output logic [N_REQ-1:0]              in_ready,
   output logic [N_REQ-1:0]              grant_onehot,
   output logic                          locked,
   output logic                          out_valid,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic                          out_tail,
   output logic [BIN_WIDTH-1:0]          out_src_bin,
   input  logic                          out_ready
);

   // After reset the pointer sits on the top channel, so the search starts at
   // channel 0 and channel 0 has the highest priority.
   localparam logic [N_REQ-1:0] PTR_RESET = N_REQ'(1) << (N_REQ - 1);

   // Packet-lock state: OPEN arbitrates freely, LOCKED holds the grant on
   // r_lock_idx until that channel delivers its tail flit.
   typedef enum logic {
      ST_OPEN   = 1'b0,
      ST_LOCKED = 1'b1
   } lock_state_t;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   lock_state_t            r_lock_state;
   logic [BIN_WIDTH-1:0]   r_lock_idx;
   logic [N_REQ-1:0]       r_ptr;

   logic                   r_out_valid;
   logic [DATA_WIDTH-1:0]  r_out_data;
   logic                   r_out_tail;
   logic [BIN_WIDTH-1:0]   r_out_src_bin;

   // ---------------------------------------------------------------------
   // Combinational signals
   // ---------------------------------------------------------------------
   lock_state_t            w_lock_state_next;
   logic [BIN_WIDTH-1:0]   w_lock_idx_next;
   logic [N_REQ-1:0]       w_ptr_next;

   logic [BIN_WIDTH-1:0]   w_ptr_bin;
   logic [N_REQ-1:0]       w_grant;
   logic                   w_can_load;
   logic                   w_xfer;
   logic [BIN_WIDTH-1:0]   w_win_bin;
   logic [DATA_WIDTH-1:0]  w_win_data;
   logic                   w_win_tail;

   // One-hot to binary by OR-ing the indices of set bits; a zero vector maps
   // to index 0, which is also the constant result when N_REQ is 1.
   function automatic logic [BIN_WIDTH-1:0] f_onehot_to_bin(input logic [N_REQ-1:0] oh);
      logic [BIN_WIDTH-1:0] bin;
      bin = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (oh[i]) begin
            bin = bin | BIN_WIDTH'(i);
         end
      end
      return bin;
   endfunction

   assign w_ptr_bin = f_onehot_to_bin(r_ptr);

   // Output register can take a new flit when empty or draining this cycle.
   assign w_can_load = !r_out_valid || out_ready;

   // Grant selection: the locked channel only, or the first valid channel
   // searching upward from the channel after the last-served one.
   always_comb begin : p_grant
      int v_ptr;
      int v_dist;
      int v_best;
      int v_best_dist;
      // NOTE: every variable written here gets a default first, so no path
      // can leave a value undefined and turn the logic into a latch.
      v_ptr       = int'(w_ptr_bin);
      v_dist      = 0;
      v_best      = 0;
      v_best_dist = N_REQ;
      w_grant     = '0;
      if (r_lock_state == ST_LOCKED) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (r_lock_idx == BIN_WIDTH'(i)) begin
               w_grant[i] = in_valid[i];
            end
         end
      end else begin
         // Distance 0 is the channel right after the pointer; the pointer
         // channel itself gets the largest distance and is searched last.
         for (int i = 0; i < N_REQ; i++) begin
            v_dist = i - v_ptr - 1;
            if (v_dist < 0) begin
               v_dist = v_dist + N_REQ;
            end
            if (in_valid[i] && (v_dist < v_best_dist)) begin
               v_best_dist = v_dist;
               v_best      = i;
            end
         end
         for (int i = 0; i < N_REQ; i++) begin
            w_grant[i] = (v_best_dist < N_REQ) && (v_best == i);
         end
      end
   end

   // Route the winning channel's flit and tail toward the output register.
   always_comb begin
      w_win_data = '0;
      w_win_tail = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_grant[i]) begin
            w_win_data = w_win_data | in_data[i*DATA_WIDTH +: DATA_WIDTH];
            w_win_tail = w_win_tail | in_tail[i];
         end
      end
   end

   assign w_win_bin = f_onehot_to_bin(w_grant);

   // Accept only on the granted channel, only when the output can load, and
   // never while reset is held.
   assign in_ready = reset ? '0 : (w_grant & {N_REQ{w_can_load}});
   assign w_xfer   = |(in_valid & in_ready);

   // Next lock state, lock index and round-robin pointer from this cycle's
   // transfer.
   always_comb begin
      w_lock_state_next = r_lock_state;
      w_lock_idx_next   = r_lock_idx;
      w_ptr_next        = r_ptr;
      if (w_xfer) begin
         if (HOLD_ENABLE) begin
            if (w_win_tail) begin
               // Packet complete (or single-flit packet): release and rotate.
               w_lock_state_next = ST_OPEN;
               w_ptr_next        = w_grant;
            end else begin
               w_lock_state_next = ST_LOCKED;
               w_lock_idx_next   = w_win_bin;
            end
         end else begin
            w_ptr_next = w_grant;
         end
      end
   end

   // Lock state, lock index and pointer registers; all cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         r_lock_state <= ST_OPEN;
         r_lock_idx   <= '0;
         r_ptr        <= PTR_RESET;
      end else begin
         r_lock_state <= w_lock_state_next;
         r_lock_idx   <= w_lock_idx_next;
         r_ptr        <= w_ptr_next;
      end
   end

   // Output register: load on transfer, empty on drain, otherwise hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_valid   <= 1'b0;
         r_out_data    <= '0;
         r_out_tail    <= 1'b0;
         r_out_src_bin <= '0;
      end else if (w_xfer) begin
         r_out_valid   <= 1'b1;
         r_out_data    <= w_win_data;
         r_out_tail    <= w_win_tail;
         r_out_src_bin <= w_win_bin;
      end else if (out_ready) begin
         r_out_valid   <= 1'b0;
      end
   end

   assign grant_onehot = w_grant;
   assign locked       = (r_lock_state == ST_LOCKED);
   assign out_valid    = r_out_valid;
   assign out_data     = r_out_data;
   assign out_tail     = r_out_tail;
   assign out_src_bin  = r_out_src_bin;

   // Structural invariants of the handshake.
   a_ready_onehot0: assert property (@(posedge clk) disable iff (reset)
      $onehot0(in_ready));
   a_grant_onehot0: assert property (@(posedge clk) disable iff (reset)
      $onehot0(grant_onehot));
   a_grant_valid:   assert property (@(posedge clk) disable iff (reset)
      (grant_onehot & ~in_valid) == '0);

endmodule
